battleship_player_turn: RTL and testbench

- Parametrised player-turn engine for the battleship game: NxN board, configurable fleet size, life count and turn timeout.
- Accepts a row/column shot from the player input logic through a valid/ready handshake and rejects off-board or repeated shots.
- Resolves hit/miss against the flattened enemy ship map and keeps shot/hit maps, hit count, life, and sticky win/lose flags.
- Sits between the input debouncer/selector and the top-level game controller, which grants turns with turn_start and consumes turn_done.

---
 rtl/battleship_player_turn.sv | 206 ++++++++++++++++++++
 tb/tb_battleship_player_turn.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/battleship_player_turn.sv
// battleship_player_turn
//   Player-turn engine for the battleship game. Once the game controller
//   grants a turn, it takes one row/column shot over a valid/ready handshake.
//   Off-board and repeated shots are rejected. An accepted shot is resolved
//   against the enemy ship map. The block tracks shot/hit maps, the hit
//   count, player life and sticky win/lose flags.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   turn_start      controller grants a turn (ignored outside IDLE)
//   sel_valid/row/col/ready/reject
//                   shot request handshake; reject is a 1-cycle pulse
//   enemy_ships     flattened ship occupancy, bit = row*BOARD_N+col
//   enemy_hit       opponent hit the player's fleet this cycle
//   shot_map, hit_map, hit_count, player_hit
//                   shot bookkeeping; player_hit holds the last result
//   turn_done, turn_timeout
//                   end-of-turn pulses (turn_timeout only on forfeit)
//   player_life, player_win, player_lose
//                   life counter and sticky outcome flags
module battleship_player_turn #(
  parameter int BOARD_N        = 5,
  parameter int SHIP_CELLS     = 5,
  parameter int MAX_LIFE       = 5,
  parameter int TIMEOUT_CYCLES = 15,
  localparam int CW = ($clog2(BOARD_N) < 1) ? 1 : $clog2(BOARD_N),
  localparam int NC = BOARD_N * BOARD_N,
  localparam int HW = ($clog2(SHIP_CELLS + 1) < 1) ? 1 : $clog2(SHIP_CELLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          turn_start,
  input  logic          sel_valid,
  input  logic [CW-1:0] sel_row,
  input  logic [CW-1:0] sel_col,
  output logic          sel_ready,
  output logic          sel_reject,
  input  logic [NC-1:0] enemy_ships,
  input  logic          enemy_hit,
  output logic [NC-1:0] shot_map,
  output logic [NC-1:0] hit_map,
  output logic [HW-1:0] hit_count,
  output logic          player_hit,
  output logic          turn_done,
  output logic          turn_timeout,
  output logic [3:0]    player_life,
  output logic          player_win,
  output logic          player_lose
);

  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SEL,
    S_RESOLVE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [NC-1:0]   shot_q, shot_d;
  logic [NC-1:0]   hitm_q, hitm_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic            phit_q, phit_d;
  logic            done_q, done_d;
  logic            tmo_q, tmo_d;
  logic            rej_q, rej_d;
  logic [3:0]      life_q, life_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;

  logic [NC-1:0]   sel_mask;
  logic [NC-1:0]   cur_mask;
  logic            sel_fresh;
  logic            cur_hit;

  // One-hot cell masks. An off-board coordinate matches no cell, which
  // gives an all-zero mask, so the on-board test is simply "mask non-zero".
  always_comb begin
    sel_mask = '0;
    cur_mask = '0;
    for (int unsigned r = 0; r < BOARD_N; r++) begin
      for (int unsigned c = 0; c < BOARD_N; c++) begin
        if (sel_row == CW'(r) && sel_col == CW'(c)) sel_mask[r*BOARD_N+c] = 1'b1;
        if (row_q   == CW'(r) && col_q   == CW'(c)) cur_mask[r*BOARD_N+c] = 1'b1;
      end
    end
  end

  assign sel_fresh = (|sel_mask) && ((shot_q & sel_mask) == '0);
  assign cur_hit   = |(enemy_ships & cur_mask);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    row_d   = row_q;
    col_d   = col_q;
    shot_d  = shot_q;
    hitm_d  = hitm_q;
    hc_d    = hc_q;
    phit_d  = phit_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    rej_d   = 1'b0;
    life_d  = life_q;
    win_d   = win_q;
    lose_d  = lose_q;

    case (state_q)
      S_IDLE: begin
        if (turn_start && !win_q && !lose_q) begin
          state_d = S_WAIT_SEL;
          timer_d = TW'(TIMEOUT_CYCLES);
        end
      end
      S_WAIT_SEL: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        // An accepted shot takes priority over a timer expiring on the same edge.
        if (sel_valid && sel_fresh) begin
          row_d   = sel_row;
          col_d   = sel_col;
          state_d = S_RESOLVE;
        end else begin
          if (sel_valid) rej_d = 1'b1;
          // A timer loaded with zero never reaches 1, so a zero timeout never expires.
          if (timer_q == TW'(1)) begin
            done_d  = 1'b1;
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RESOLVE: begin
        shot_d = shot_q | cur_mask;
        phit_d = cur_hit;
        if (cur_hit) begin
          hitm_d = hitm_q | cur_mask;
          if (hc_q != HW'(SHIP_CELLS)) hc_d = hc_q + 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d = 1'b1;
        if (hc_q == HW'(SHIP_CELLS) && !lose_q) win_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A win decided on this same edge takes precedence over losing the last life.
    if (enemy_hit && !win_q && life_q != 4'd0) begin
      life_d = life_q - 4'd1;
      if (life_q == 4'd1 && !win_d) lose_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      shot_q  <= '0;
      hitm_q  <= '0;
      hc_q    <= '0;
      phit_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      rej_q   <= 1'b0;
      life_q  <= 4'(MAX_LIFE);
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      row_q   <= row_d;
      col_q   <= col_d;
      shot_q  <= shot_d;
      hitm_q  <= hitm_d;
      hc_q    <= hc_d;
      phit_q  <= phit_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      rej_q   <= rej_d;
      life_q  <= life_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign sel_ready    = (state_q == S_WAIT_SEL);
  assign sel_reject   = rej_q;
  assign shot_map     = shot_q;
  assign hit_map      = hitm_q;
  assign hit_count    = hc_q;
  assign player_hit   = phit_q;
  assign turn_done    = done_q;
  assign turn_timeout = tmo_q;
  assign player_life  = life_q;
  assign player_win   = win_q;
  assign player_lose  = lose_q;

endmodule

// File: tb/tb_battleship_player_turn.sv
// Testbench for battleship_player_turn: a scoreboard queue of expected turn
// results is filled as shots are driven and drained on each turn_done.
module tb_battleship_player_turn;

  localparam int N  = 5;
  localparam int NC = N * N;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, turn_start, sel_valid, enemy_hit;
  logic [2:0]    sel_row, sel_col;
  logic [NC-1:0] enemy_ships;
  logic          sel_ready, sel_reject, player_hit, turn_done, turn_timeout;
  logic [NC-1:0] shot_map, hit_map;
  logic [2:0]    hit_count;
  logic [3:0]    player_life;
  logic          player_win, player_lose;

  // second instance with the timeout disabled
  logic          ts0, zero_bit;
  logic          sel_ready_0, sel_reject_0, player_hit_0, turn_done_0, turn_timeout_0;
  logic [NC-1:0] shot_map_0, hit_map_0;
  logic [2:0]    hit_count_0;
  logic [3:0]    player_life_0;
  logic          player_win_0, player_lose_0;

  battleship_player_turn #(.BOARD_N(5), .SHIP_CELLS(5), .MAX_LIFE(5), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .turn_start(turn_start), .sel_valid(sel_valid),
    .sel_row(sel_row), .sel_col(sel_col), .sel_ready(sel_ready), .sel_reject(sel_reject),
    .enemy_ships(enemy_ships), .enemy_hit(enemy_hit), .shot_map(shot_map), .hit_map(hit_map),
    .hit_count(hit_count), .player_hit(player_hit), .turn_done(turn_done),
    .turn_timeout(turn_timeout), .player_life(player_life), .player_win(player_win),
    .player_lose(player_lose));

  battleship_player_turn #(.BOARD_N(5), .SHIP_CELLS(5), .MAX_LIFE(5), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .turn_start(ts0), .sel_valid(zero_bit),
    .sel_row(3'd0), .sel_col(3'd0), .sel_ready(sel_ready_0), .sel_reject(sel_reject_0),
    .enemy_ships(enemy_ships), .enemy_hit(zero_bit), .shot_map(shot_map_0), .hit_map(hit_map_0),
    .hit_count(hit_count_0), .player_hit(player_hit_0), .turn_done(turn_done_0),
    .turn_timeout(turn_timeout_0), .player_life(player_life_0), .player_win(player_win_0),
    .player_lose(player_lose_0));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          tmo;
    logic          hit;
    logic [NC-1:0] smap;
    logic [NC-1:0] hmap;
    logic [2:0]    hc;
  } exp_t;

  exp_t          expq[$];
  exp_t          mon_e;

  // reference model state
  logic [NC-1:0] m_shot, m_hit;
  int            m_hc, m_life;
  logic          m_win, m_lose;

  task automatic model_reset();
    m_shot = '0; m_hit = '0; m_hc = 0; m_life = 5; m_win = 1'b0; m_lose = 1'b0;
    expq.delete();
  endtask

  always @(negedge clk) begin
    if (rst && turn_done) begin
      if (expq.size() == 0) begin
        check("unexpected_done", turn_done, 1'b0);
      end else begin
        mon_e = expq.pop_front();
        check("done_timeout", turn_timeout, mon_e.tmo);
        if (!mon_e.tmo) check("done_hit", player_hit, mon_e.hit);
        check("done_shot_map", shot_map, mon_e.smap);
        check("done_hit_map", hit_map, mon_e.hmap);
        check("done_hit_count", hit_count, mon_e.hc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_turn();
    turn_start = 1'b1;
    @(negedge clk);
    turn_start = 1'b0;
  endtask

  task automatic enemy_pulse();
    enemy_hit = 1'b1;
    @(negedge clk);
    enemy_hit = 1'b0;
    if (!m_win && m_life > 0) begin
      m_life--;
      if (m_life == 0) m_lose = 1'b1;
    end
    check("life", player_life, m_life);
    check("lose", player_lose, m_lose);
  endtask

  // Fire a legal shot; optionally pulse enemy_hit on the edge that ends the turn.
  task automatic shot(input int r, input int c, input bit eh_done);
    int   idx;
    logic h;
    exp_t e;
    idx = r * N + c;
    check("ready_before_shot", sel_ready, 1'b1);
    sel_valid = 1'b1;
    sel_row   = 3'(r);
    sel_col   = 3'(c);
    h = enemy_ships[idx];
    m_shot[idx] = 1'b1;
    if (h) begin
      m_hit[idx] = 1'b1;
      if (m_hc < 5) m_hc++;
    end
    e.tmo = 1'b0; e.hit = h; e.smap = m_shot; e.hmap = m_hit; e.hc = 3'(m_hc);
    expq.push_back(e);
    @(negedge clk);                 // accepted at edge t
    sel_valid = 1'b0;
    check("resolve_not_ready", sel_ready, 1'b0);
    check("no_done_t", turn_done, 1'b0);
    @(negedge clk);                 // after t+1
    check("hit_t1", player_hit, h);
    check("hit_count_t1", hit_count, m_hc);
    check("no_done_t1", turn_done, 1'b0);
    if (eh_done) enemy_hit = 1'b1;
    @(negedge clk);                 // after t+2
    if (eh_done) begin
      enemy_hit = 1'b0;
      if (m_life > 0) m_life--;
    end
    check("done_t2", turn_done, 1'b1);
    if (m_hc == 5) m_win = 1'b1;
    check("win", player_win, m_win);
  endtask

  task automatic reject(input int r, input int c);
    sel_valid = 1'b1;
    sel_row   = 3'(r);
    sel_col   = 3'(c);
    @(negedge clk);
    sel_valid = 1'b0;
    check("reject_pulse", sel_reject, 1'b1);
    check("reject_still_ready", sel_ready, 1'b1);
    check("reject_map", shot_map, m_shot);
    @(negedge clk);
    check("reject_cleared", sel_reject, 1'b0);
  endtask

  initial begin
    int   k;
    int   n0;
    exp_t et;
    rst = 1'b0; turn_start = 1'b0; sel_valid = 1'b0; enemy_hit = 1'b0;
    sel_row = '0; sel_col = '0; ts0 = 1'b0; zero_bit = 1'b0;
    enemy_ships = '0;
    enemy_ships[13] = 1'b1; enemy_ships[1] = 1'b1; enemy_ships[7] = 1'b1;
    enemy_ships[19] = 1'b1; enemy_ships[24] = 1'b1;
    model_reset();
    cyc(2);
    check("rst_life", player_life, 5);
    check("rst_shot_map", shot_map, '0);
    check("rst_hit_map", hit_map, '0);
    check("rst_hit_count", hit_count, 0);
    check("rst_ready", sel_ready, 1'b0);
    check("rst_done", turn_done, 1'b0);
    check("rst_win_lose", {player_win, player_lose, player_hit, sel_reject}, 4'b0);
    rst = 1'b1;
    cyc(1);

    // hit on (2,3)
    start_turn();
    shot(2, 3, 0);
    // repeat and off-board rejects, then a miss
    start_turn();
    reject(2, 3);
    reject(5, 1);
    shot(0, 0, 0);

    // timeout
    et.tmo = 1'b1; et.hit = 1'b0; et.smap = m_shot; et.hmap = m_hit; et.hc = 3'(m_hc);
    expq.push_back(et);
    start_turn();
    k = 0;
    while (!turn_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, 15);
    cyc(1);
    check("timeout_done_pulse", turn_done, 1'b0);
    check("timeout_idle", sel_ready, 1'b0);

    // timeout disabled
    ts0 = 1'b1;
    @(negedge clk);
    ts0 = 1'b0;
    n0 = 0;
    repeat (100) begin
      @(negedge clk);
      if (turn_done_0) n0++;
    end
    check("no_timeout_count", n0, 0);
    check("no_timeout_ready", sel_ready_0, 1'b1);

    // remaining hits -> win
    start_turn(); shot(0, 1, 0);
    start_turn(); shot(1, 2, 0);
    start_turn(); shot(3, 4, 0);
    start_turn(); shot(4, 4, 0);
    check("win_final", player_win, 1'b1);
    start_turn();
    cyc(1);
    check("win_blocks_turn", sel_ready, 1'b0);
    enemy_pulse();

    // reset in the middle of WAIT_SEL
    rst = 1'b0; cyc(1); rst = 1'b1; model_reset(); cyc(1);
    start_turn(); shot(2, 3, 0);
    start_turn();
    cyc(3);
    rst = 1'b0;
    #1;
    check("midrst_shot_map", shot_map, '0);
    check("midrst_hit_map", hit_map, '0);
    check("midrst_hit_count", hit_count, 0);
    check("midrst_ready", sel_ready, 1'b0);
    check("midrst_life", player_life, 5);
    check("midrst_flags", {player_hit, turn_done, turn_timeout, sel_reject, player_win, player_lose}, 6'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(20);

    // lose: six enemy hits, life saturates at 0
    for (int i = 0; i < 6; i++) enemy_pulse();
    start_turn();
    cyc(1);
    check("lose_blocks_turn", sel_ready, 1'b0);

    // final hit and last life on the same edge
    rst = 1'b0; cyc(1); rst = 1'b1; model_reset(); cyc(1);
    start_turn(); shot(1, 2, 0);
    start_turn(); shot(3, 4, 0);
    start_turn(); shot(4, 4, 0);
    start_turn(); shot(0, 1, 0);
    for (int i = 0; i < 4; i++) enemy_pulse();
    start_turn(); shot(2, 3, 1);
    check("tie_win", player_win, 1'b1);
    check("tie_lose", player_lose, 1'b0);
    check("tie_life", player_life, m_life);
    cyc(2);
    check("queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
